booth_mul_ctrl: RTL and testbench

// Iterative controller for the radix-4 Booth multiplier. Owns one shared partial-product

---
 rtl/booth_mul_ctrl.sv | 155 +++++++++++++++
 tb/tb_booth_mul_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_ctrl.sv
// Radix-4 Booth multiplier sequencer. Drives one shared partial-product
// generator, one Booth group per cycle, and accumulates a 128-bit product.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// BUSY  | stepping Booth groups 0..N-1 through the generator
// DONE  | product final; result registered and held until consumed
module booth_mul_ctrl #(
  parameter int XLEN = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          op_signed,
  input  logic                op_w,
  input  logic [XLEN-1:0]     src_a,
  input  logic [XLEN-1:0]     src_b,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     result_hi,
  output logic [XLEN-1:0]     result_lo,
  output logic [XLEN:0]       pp_x,
  output logic                pp_neg,
  output logic                pp_one,
  output logic                pp_two,
  output logic                pp_zero,
  input  logic [2*XLEN-1:0]   pp_p
);

  localparam int HALF = XLEN / 2;
  localparam logic [5:0] LAST_FULL = 6'(XLEN / 2);      // N-1 for full width
  localparam logic [5:0] LAST_WORD = 6'(XLEN / 4);      // N-1 for word op

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [XLEN:0]       r_ext_a;
  logic [XLEN+2:0]     r_mb;        // {ext_b, y[-1]}; low 3 bits are the current window
  logic [2*XLEN-1:0]   r_acc;
  logic [5:0]          r_cnt;
  logic [5:0]          r_last;
  logic                r_op_w;
  logic                r_out_valid;
  logic [XLEN-1:0]     r_res_hi;
  logic [XLEN-1:0]     r_res_lo;

  logic                w_accept;
  logic                w_sign_a;
  logic                w_sign_b;
  logic [XLEN-1:0]     w_a_src;
  logic [XLEN-1:0]     w_b_src;
  logic [2*XLEN-1:0]   w_pp_shift;
  logic [2:0]          w_win;

  assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
  assign w_sign_a = op_signed[0];
  assign w_sign_b = &op_signed;
  // Word ops narrow the operands first, then share the 64-bit extension path.
  assign w_a_src  = op_w ? {{HALF{w_sign_a & src_a[HALF-1]}}, src_a[HALF-1:0]} : src_a;
  assign w_b_src  = op_w ? {{HALF{w_sign_b & src_b[HALF-1]}}, src_b[HALF-1:0]} : src_b;
  assign w_pp_shift = pp_p << {r_cnt, 1'b0};
  assign w_win    = r_mb[2:0];

  assign out_valid = r_out_valid;
  assign result_hi = r_res_hi;
  assign result_lo = r_res_lo;

  // State register; flush overrides any transition.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) r_state <= S_IDLE;
    else                 r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_BUSY;
      S_BUSY: if (r_cnt == r_last) w_next_state = S_DONE;
      S_DONE: if (r_out_valid && out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake and Booth select outputs; generator idles on zero outside BUSY.
  always_comb begin
    in_ready = (r_state == S_IDLE);
    pp_x     = '0;
    pp_neg   = 1'b0;
    pp_one   = 1'b0;
    pp_two   = 1'b0;
    pp_zero  = 1'b1;
    if (r_state == S_BUSY) begin
      pp_x    = r_ext_a;
      pp_zero = 1'b0;
      case (w_win)
        3'b001, 3'b010: pp_one = 1'b1;
        3'b011:         pp_two = 1'b1;
        3'b100:         begin pp_two = 1'b1; pp_neg = 1'b1; end
        3'b101, 3'b110: begin pp_one = 1'b1; pp_neg = 1'b1; end
        default:        pp_zero = 1'b1;
      endcase
    end
  end

  // Operand latch, accumulation and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ext_a     <= '0;
      r_mb        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_last      <= '0;
      r_op_w      <= 1'b0;
      r_out_valid <= 1'b0;
      r_res_hi    <= '0;
      r_res_lo    <= '0;
    end else if (flush) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_ext_a <= {w_sign_a & w_a_src[XLEN-1], w_a_src};
          r_mb    <= {{2{w_sign_b & w_b_src[XLEN-1]}}, w_b_src, 1'b0};
          r_acc   <= '0;
          r_cnt   <= '0;
          r_last  <= op_w ? LAST_WORD : LAST_FULL;
          r_op_w  <= op_w;
        end
        S_BUSY: begin
          r_acc <= r_acc + w_pp_shift;
          r_cnt <= r_cnt + 6'd1;
          r_mb  <= {r_mb[XLEN+2], r_mb[XLEN+2], r_mb[XLEN+2:2]};
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_res_hi    <= r_op_w ? '0 : r_acc[2*XLEN-1:XLEN];
            r_res_lo    <= r_op_w ? {{HALF{r_acc[HALF-1]}}, r_acc[HALF-1:0]}
                                  : r_acc[XLEN-1:0];
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Bench for booth_mul_ctrl: behavioural partial-product generator plus
// arithmetic reference product, directed cases and random operations.
module tb_booth_mul_ctrl;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op_signed = 2'b00;
  logic          op_w = 1'b0;
  logic [63:0]   src_a = '0;
  logic [63:0]   src_b = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   result_hi;
  logic [63:0]   result_lo;
  logic [64:0]   pp_x;
  logic          pp_neg, pp_one, pp_two, pp_zero;
  logic [127:0]  pp_p;

  int n_checks = 0;
  int n_errs = 0;

  booth_mul_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_signed(op_signed), .op_w(op_w), .src_a(src_a), .src_b(src_b),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result_hi(result_hi), .result_lo(result_lo), .pp_x(pp_x),
    .pp_neg(pp_neg), .pp_one(pp_one), .pp_two(pp_two), .pp_zero(pp_zero),
    .pp_p(pp_p)
  );

  always #5 clk = ~clk;

  // Generator: signed multiple of x selected by one/two, negated by neg.
  logic [127:0] m_xs, m_mag;
  always_comb begin
    m_xs  = {{63{pp_x[64]}}, pp_x};
    m_mag = '0;
    if (pp_two)      m_mag = m_xs << 1;
    else if (pp_one) m_mag = m_xs;
    pp_p = pp_neg ? (~m_mag + 128'd1) : m_mag;
  end

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] sg, input logic w);
    logic [127:0] ea, eb, p;
    logic sa, sb;
    sa = sg[0];
    sb = (sg == 2'b11);
    if (w) begin
      ea = sa ? {{96{a[31]}}, a[31:0]} : {96'd0, a[31:0]};
      eb = sb ? {{96{b[31]}}, b[31:0]} : {96'd0, b[31:0]};
    end else begin
      ea = sa ? {{64{a[63]}}, a} : {64'd0, a};
      eb = sb ? {{64{b[63]}}, b} : {64'd0, b};
    end
    p = ea * eb;
    if (w) return {64'd0, {32{p[31]}}, p[31:0]};
    return p;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sel(input string tag);
    check(tag, {1'b0, (32'(pp_zero) + 32'(pp_one) + 32'(pp_two)) == 32'd1, !(pp_neg && pp_zero)},
          128'b011);
  endtask

  task automatic accept(input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] sg, input logic w);
    @(negedge clk);
    check("in_ready_idle", 128'(in_ready), 128'd1);
    src_a = a; src_b = b; op_signed = sg; op_w = w; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] sg, input logic w, input int hold);
    logic [127:0] exp;
    logic [63:0] lo0;
    int cyc;
    bit got;
    exp = ref_mul(a, b, sg, w);
    accept(a, b, sg, w);
    cyc = 0;
    got = 0;
    while (cyc < 100 && !got) begin
      check_sel("booth_sel");
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) got = 1;
    end
    check("latency", 128'(cyc), w ? 128'd18 : 128'd34);
    check("result_hi", 128'(result_hi), 128'(exp[127:64]));
    check("result_lo", 128'(result_lo), 128'(exp[63:0]));
    check("in_ready_done", 128'(in_ready), 128'd0);
    lo0 = result_lo;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 128'(out_valid), 128'd1);
      check("hold_lo", 128'(result_lo), 128'(lo0));
      check("hold_hi", 128'(result_hi), 128'(exp[127:64]));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_drop", 128'(out_valid), 128'd0);
    check("in_ready_after", 128'(in_ready), 128'd1);
  endtask

  initial begin
    int seen;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_res", {result_hi, result_lo}, 128'd0);
    check("rst_pp", {pp_x, pp_neg, pp_one, pp_two, pp_zero}, 128'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic
    run_op(64'd3, 64'd5, 2'b00, 1'b0, 0);
    run_op(-64'sd2, 64'd3, 2'b11, 1'b0, 0);
    run_op(-64'sd1, -64'sd1, 2'b11, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 0);
    run_op(64'h0000_0000_7FFF_FFFF, 64'd2, 2'b11, 1'b1, 0);
    run_op(64'h1234_5678_8000_0000, 64'hDEAD_BEEF_0000_0003, 2'b11, 1'b1, 5);

    // Flush at cnt=10
    accept(64'd123456789, 64'd987654321, 2'b00, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_in_ready", 128'(in_ready), 128'd1);
    check("flush_out_valid", 128'(out_valid), 128'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("flush_no_result", 128'(seen), 128'd0);
    run_op(64'd7, 64'd6, 2'b00, 1'b0, 0);

    // Reset during BUSY
    accept(64'hAAAA_5555_AAAA_5555, 64'h7777_7777_7777_7777, 2'b11, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_res", {result_hi, result_lo}, 128'd0);
    check("mid_rst_pp", {pp_x, pp_neg, pp_one, pp_two, pp_zero}, 128'b1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("mid_rst_no_result", 128'(seen), 128'd0);

    // in_valid with flush in IDLE is not accepted
    @(negedge clk);
    src_a = 64'd5; src_b = 64'd9; op_signed = 2'b00; op_w = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("vflush_in_ready", 128'(in_ready), 128'd1);
    check("vflush_pp_x", 128'(pp_x), 128'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("vflush_no_result", 128'(seen), 128'd0);

    // Random operations
    for (int t = 0; t < 16; t++) begin
      logic [63:0] ra, rb;
      logic [1:0] rs;
      logic rw;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, rw, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
